// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy initiator: reads src range, writes dst range, one word per two cycles.
// Drives a single-port memory with asynchronous read and synchronous write.
module mem_copy_engine #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned VOLUME = 16,
    localparam int unsigned AW    = $clog2(VOLUME)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [AW-1:0]    i_src,
    input  logic [AW-1:0]    i_dst,
    input  logic [AW:0]      i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic [AW-1:0]    o_mem_addr,
    output logic             o_mem_we,
    output logic [WIDTH-1:0] o_mem_wdata,
    input  logic [WIDTH-1:0] i_mem_rdata
);

    localparam logic [AW:0]   LenMax   = (AW + 1)'(VOLUME);
    localparam logic [AW-1:0] AddrLast = AW'(VOLUME - 1);
    localparam logic [AW:0]   LenOne   = (AW + 1)'(1);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [AW-1:0]    r_cur_src;
    logic [AW-1:0]    w_cur_src_next;
    logic [AW-1:0]    r_cur_dst;
    logic [AW-1:0]    w_cur_dst_next;
    logic [AW:0]      r_remaining;
    logic [AW:0]      w_remaining_next;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_next;
    logic [AW:0]      w_len_clamped;

    // Increment modulo VOLUME, correct for non-power-of-2 depths too.
    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
        return (a == AddrLast) ? '0 : a + AW'(1);
    endfunction

    assign w_len_clamped = (i_len > LenMax) ? LenMax : i_len;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_cur_src   <= '0;
            r_cur_dst   <= '0;
            r_remaining <= '0;
            r_data      <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cur_src   <= w_cur_src_next;
            r_cur_dst   <= w_cur_dst_next;
            r_remaining <= w_remaining_next;
            r_data      <= w_data_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cur_src_next   = r_cur_src;
        w_cur_dst_next   = r_cur_dst;
        w_remaining_next = r_remaining;
        w_data_next      = r_data;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_cur_src_next   = i_src;
                    w_cur_dst_next   = i_dst;
                    w_remaining_next = w_len_clamped;
                    w_state_next     = (w_len_clamped != '0) ? StRead : StDone;
                end
            end
            StRead: begin
                w_data_next  = i_mem_rdata;
                w_state_next = StWrite;
            end
            StWrite: begin
                w_cur_src_next   = wrap_inc(r_cur_src);
                w_cur_dst_next   = wrap_inc(r_cur_dst);
                w_remaining_next = r_remaining - LenOne;
                w_state_next     = (r_remaining == LenOne) ? StDone : StRead;
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_comb begin
        o_mem_addr = '0;
        unique case (r_state)
            StRead:  o_mem_addr = r_cur_src;
            StWrite: o_mem_addr = r_cur_dst;
            default: o_mem_addr = '0;
        endcase
    end

    assign o_mem_we    = (r_state == StWrite);
    assign o_busy      = (r_state == StRead) || (r_state == StWrite);
    assign o_done      = (r_state == StDone);
    assign o_mem_wdata = r_data;

endmodule
